sc_stream_sequencer: RTL and testbench
======================================

# sc_stream_sequencer

Sequencer that drives one stochastic-computing (SC) evaluation datapath for a bounded bitstream length. It owns the 8-bit LFSR random source and the datapath's unit-delay feedback flop. It accepts a job (operand plus seed) over a valid/ready handshake and steps the datapath for `LEN` clocks. It counts ones on the datapath's stream output and returns that count as the binary result. It sits between the host/job queue and the combinational SC circuit, which never sees a clock of its own.

## Interface
Parameters:
- `LEN`, default 255: bitstream length in counted cycles; legal range 1..255.
- `WARMUP`, default 8: uncounted settling cycles before counting; only used when `SC_SEQ_WARMUP_EN` is defined.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, 1: job offered.
- `req_ready`, out, 1: sequencer can accept a job.
- `req_b`, in, 8: binary operand forwarded to the datapath.
- `req_seed`, in, 8: LFSR seed.
- `sc_rand`, out, 8: current LFSR state, fed to the datapath's random input.
- `sc_b`, out, 8: latched operand, fed to the datapath's comparator input.
- `sc_dly_q`, out, 1: delay-flop output, fed back to the datapath.
- `sc_dly_d`, in, 1: next delay value from the datapath.
- `sc_out`, in, 1: datapath stream output bit.
- `resp_valid`, out, 1: result available.
- `resp_ready`, in, 1: consumer accepts the result.
- `resp_count`, out, 8: number of ones observed on `sc_out`.
- `busy`, out, 1: high in WARM or RUN.

## Operation
States are IDLE, WARM, RUN and DONE.
- **IDLE:** `req_ready`=1. On `req_valid`:
  - latch `req_b` into `sc_b`.
  - load `sc_rand` with `req_seed`; a seed of 8'h00 is replaced by 8'h01 to avoid LFSR lockup.
  - clear the delay flop and the count.
  - go to WARM if the macro is defined, otherwise go to RUN.
- **LFSR step:** taken every cycle in WARM and RUN, and held in IDLE and DONE.
  - next[6:0] = s[7:1].
  - next[7] = s[6]^s[5]^s[4]^s[0].
- **Delay flop:** `sc_dly_q` <= `sc_dly_d` every WARM/RUN cycle; held otherwise.
- **WARM:** runs for exactly `WARMUP` cycles with no counting, then goes to RUN.
- **RUN:** each cycle with `sc_out`=1 increments the count.
  - After exactly `LEN` RUN cycles, go to DONE.
  - The count saturates at 255; for legal `LEN` it cannot overflow.
- **DONE:** `resp_valid`=1 and `resp_count` holds the count. On `resp_ready`, go to IDLE.
- While busy, `req_valid` is ignored and `req_ready`=0. A request is never lost, because the requester holds `req_valid` until it sees `req_ready`.

## Timing
- **Reset values:**
  - `req_ready`=1, `resp_valid`=0, `resp_count`=0, `busy`=0.
  - `sc_rand`=8'h01, `sc_b`=0, `sc_dly_q`=0, state IDLE.
- **Reset mid-job:** asserting `rst_n`=0 in any state aborts the job immediately and returns all outputs to their reset values. No response is produced.
- **Acceptance:** the handshake cycle (`req_valid`&`req_ready`) is cycle 0.
  - Cycle 1 presents the seed on `sc_rand` and is the first WARM/RUN cycle.
  - The first counted `sc_out` sample is the one presented with the seed (no warmup), or with the state after `WARMUP` steps (warmup enabled).
- **Latency:** `resp_valid` rises at cycle 1+`WARMUP`+`LEN`, where `WARMUP` is 0 when the macro is undefined.
- **Response:** `resp_valid` stays high until `resp_ready` is sampled high. `req_ready` returns in the cycle after that acceptance; there is no same-cycle IDLE re-accept.
- **Combinational path:** `sc_out` and `sc_dly_d` are combinational from `sc_rand`/`sc_b`/`sc_dly_q`. The sequencer registers all of them, so there is no combinational path from inputs to outputs.

## Configuration
- `SC_SEQ_WARMUP_EN` defined: the WARM state exists and discards `WARMUP` cycles so the delay feedback and correlation settle before counting.
- `SC_SEQ_WARMUP_EN` undefined: there is no WARM state, the `WARMUP` parameter is unused, and IDLE goes directly to RUN.

## Structure
- **Shared package `sc_pkg`:**
  - state enum: IDLE, WARM, RUN, DONE.
  - `SC_W`=8.
  - LFSR tap constant and zero-seed substitute 8'h01.
  - a `lfsr_next` function, so the datapath model and testbench step identically.
- **Sub-module `sc_lfsr8`:** load, enable, 8-bit state. The state machine, counters and delay flop live in the top level.

## Test plan
- **LFSR step:** seed 8'h01 with a stub where `sc_out`=0 → `sc_rand` reads 8'h01 then 8'h80 on the next cycle; `resp_count`=0 after `LEN`.
- **Constant-one stub:** stub `sc_out`=1, `LEN`=255, macro off → `resp_valid` at cycle 256 with `resp_count`=255. With the macro on and `WARMUP`=8 → `resp_valid` at cycle 264, count 255.
- **Zero seed and busy handling:** seed 8'h00 → `sc_rand`=8'h01 on cycle 1. A second `req_valid` during RUN is not accepted and is accepted in the cycle after the response handshake.
- **Response backpressure:** hold `resp_ready`=0 for 10 cycles → `resp_valid`, `resp_count` and LFSR state are stable throughout; release → IDLE next cycle.
- **Delay feedback:** stub `sc_dly_d`=~`sc_dly_q`, `sc_out`=`sc_dly_q`, `LEN`=10, macro off → `resp_count`=5.
- **Reset mid-run:** assert `rst_n` low at RUN cycle 50 → outputs return to reset values asynchronously. A new job after release produces a correct, independent count.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and LFSR helpers for the stochastic-computing sequencer and its datapath models.
package sc_pkg;

  localparam int SC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sc_state_e;

  // Feedback taps s[6], s[5], s[4], s[0] shifted into bit 7.
  localparam logic [SC_W-1:0] LFSR_TAPS     = 8'h71;
  localparam logic [SC_W-1:0] LFSR_ZERO_SUB = 8'h01;

  function automatic logic [SC_W-1:0] lfsr_next(input logic [SC_W-1:0] s);
    return {^(s & LFSR_TAPS), s[SC_W-1:1]};
  endfunction

  function automatic logic [SC_W-1:0] lfsr_seed_fix(input logic [SC_W-1:0] seed);
    return (seed == '0) ? LFSR_ZERO_SUB : seed;
  endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// 8-bit Fibonacci LFSR random source with synchronous seed load and step enable.
module sc_lfsr8
  import sc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [SC_W-1:0] seed_i,
  output logic [SC_W-1:0] state_o
);

  logic [SC_W-1:0] state_q;
  logic [SC_W-1:0] state_d;

  // Load wins over stepping; an all-zero seed would lock the register forever.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = lfsr_seed_fix(seed_i);
    end else if (en_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_ZERO_SUB;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/sc_stream_sequencer.sv
// Job sequencer for a combinational SC datapath: owns LFSR, delay flop and ones counter.
// Define SC_SEQ_WARMUP_EN to insert WARMUP uncounted settling cycles before counting.
module sc_stream_sequencer
  import sc_pkg::*;
#(
  parameter int LEN    = 255,
  parameter int WARMUP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SC_W-1:0] req_b,
  input  logic [SC_W-1:0] req_seed,
  output logic [SC_W-1:0] sc_rand,
  output logic [SC_W-1:0] sc_b,
  output logic            sc_dly_q,
  input  logic            sc_dly_d,
  input  logic            sc_out,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [SC_W-1:0] resp_count,
  output logic            busy
);

  // One cycle counter serves both phases, so it is sized for the longer one.
  localparam int CYC_MAX = (LEN > WARMUP) ? LEN : WARMUP;
  localparam int CYC_W   = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] RUN_LAST = CYC_W'(LEN - 1);
`ifdef SC_SEQ_WARMUP_EN
  localparam logic [CYC_W-1:0] WARM_LAST = CYC_W'((WARMUP > 0) ? WARMUP - 1 : 0);
`endif

  sc_state_e       state_q;
  logic [CYC_W-1:0] cyc_q;
  logic [SC_W-1:0] count_q;
  logic [SC_W-1:0] b_q;
  logic            dly_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            busy_q;
  logic            accept;

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + 1'b1 : c;
  endfunction

  assign accept = req_valid && req_ready_q;

  sc_lfsr8 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .en_i    (busy_q),
    .seed_i  (req_seed),
    .state_o (sc_rand)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      count_q      <= '0;
      b_q          <= '0;
      dly_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            b_q         <= req_b;
            dly_q       <= 1'b0;
            count_q     <= '0;
            cyc_q       <= '0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
`ifdef SC_SEQ_WARMUP_EN
            state_q     <= (WARMUP > 0) ? ST_WARM : ST_RUN;
`else
            state_q     <= ST_RUN;
`endif
          end
        end
`ifdef SC_SEQ_WARMUP_EN
        ST_WARM: begin
          dly_q <= sc_dly_d;
          if (cyc_q == WARM_LAST) begin
            cyc_q   <= '0;
            state_q <= ST_RUN;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
`endif
        ST_RUN: begin
          dly_q   <= sc_dly_d;
          count_q <= sat_inc(count_q, sc_out);
          if (cyc_q == RUN_LAST) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Re-accept only from IDLE, i.e. one cycle after the response handshake.
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_count = count_q;
  assign busy       = busy_q;
  assign sc_b       = b_q;
  assign sc_dly_q   = dly_q;

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Randomized directed bench for sc_stream_sequencer with a stubbed SC datapath and a stream-level model.
module tb_sc_stream_sequencer;

  localparam int LEN = 255;
`ifdef SC_SEQ_WARMUP_EN
  localparam int W = 8;
`else
  localparam int W = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_b;
  logic [7:0] req_seed;
  logic [7:0] sc_rand;
  logic [7:0] sc_b;
  logic       sc_dly_q;
  logic       sc_dly_d;
  logic       sc_out;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_count;
  logic       busy;

  int mode;
  int vectors;
  int errors;

  sc_stream_sequencer #(.LEN(LEN), .WARMUP(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_b      (req_b),
    .req_seed   (req_seed),
    .sc_rand    (sc_rand),
    .sc_b       (sc_b),
    .sc_dly_q   (sc_dly_q),
    .sc_dly_d   (sc_dly_d),
    .sc_out     (sc_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_count (resp_count),
    .busy       (busy)
  );

  // Datapath stubs: 0 const-zero, 1 const-one, 2 toggle feedback, 3 comparator xor delay.
  always_comb begin
    sc_out   = 1'b0;
    sc_dly_d = 1'b0;
    case (mode)
      1: sc_out = 1'b1;
      2: begin sc_out = sc_dly_q; sc_dly_d = ~sc_dly_q; end
      3: begin sc_out = (sc_rand < sc_b) ^ sc_dly_q; sc_dly_d = (sc_rand < sc_b); end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] s);
    logic fb;
    fb = s[6] ^ s[5] ^ s[4] ^ s[0];
    return {fb, s[7:1]};
  endfunction

  function automatic logic [7:0] fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // Walk W+LEN datapath evaluations, counting ones only after the warmup window.
  task automatic model(input logic [7:0] seed, input logic [7:0] b, input int m,
                       output int cnt, output logic [7:0] fin);
    logic [7:0] s;
    logic d, o, dn, c;
    s = fix(seed);
    d = 1'b0;
    cnt = 0;
    for (int i = 0; i < W + LEN; i++) begin
      c  = (s < b);
      o  = (m == 1) ? 1'b1 : (m == 2) ? d : (m == 3) ? (c ^ d) : 1'b0;
      dn = (m == 2) ? ~d : (m == 3) ? c : 1'b0;
      if (i >= W && o && cnt < 255) cnt++;
      s = step(s);
      d = dn;
    end
    fin = s;
  endtask

  // Drives cycle 0 and returns positioned in cycle 1.
  task automatic launch(input logic [7:0] seed, input logic [7:0] b, input bit keep);
    req_seed  = seed;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
    chk("seed_load", 32'(sc_rand), 32'(fix(seed)));
    chk("b_latch", 32'(sc_b), 32'(b));
    chk("busy_run", 32'(busy), 32'd1);
    chk("ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic finish_job(input logic [7:0] seed, input int exp_cnt, input logic [7:0] fin,
                            input int bp);
    int k;
    @(posedge clk); #1;
    chk("lfsr_step", 32'(sc_rand), 32'(step(fix(seed))));
    k = 2;
    while (!resp_valid && k < 1 + W + LEN + 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(1 + W + LEN));
    chk("count", 32'(resp_count), 32'(exp_cnt));
    chk("lfsr_final", 32'(sc_rand), 32'(fin));
    chk("ready_done", 32'(req_ready), 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_count", 32'(resp_count), 32'(exp_cnt));
      chk("bp_lfsr", 32'(sc_rand), 32'(fin));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    chk("lfsr_hold", 32'(sc_rand), 32'(fin));
  endtask

  task automatic run_job(input logic [7:0] seed, input logic [7:0] b, input int m, input int bp);
    int cnt;
    logic [7:0] fin;
    mode = m;
    model(seed, b, m, cnt, fin);
    launch(seed, b, 1'b0);
    finish_job(seed, cnt, fin, bp);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_count", 32'(resp_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sc_rand", 32'(sc_rand), 32'h01);
    chk("rst_sc_b", 32'(sc_b), 32'd0);
    chk("rst_dly", 32'(sc_dly_q), 32'd0);
  endtask

  initial begin
    int cnt_a, cnt_b;
    logic [7:0] fin_a, fin_b;
    logic [7:0] seed_a, seed_b, b_a, b_b;

    vectors    = 0;
    errors     = 0;
    mode       = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_b      = '0;
    req_seed   = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(8'h01, 8'h00, 0, 0);
    run_job(8'hA5, 8'h3C, 1, 10);
    run_job(8'h00, 8'($urandom_range(1, 255)), 3, 0);
    run_job(8'($urandom), 8'($urandom), 2, 0);

    // Second request offered during RUN must wait until the response handshake.
    mode   = 3;
    seed_a = 8'($urandom);
    b_a    = 8'($urandom);
    seed_b = 8'($urandom);
    b_b    = 8'($urandom);
    model(seed_a, b_a, 3, cnt_a, fin_a);
    model(seed_b, b_b, 3, cnt_b, fin_b);
    launch(seed_a, b_a, 1'b1);
    req_seed = seed_b;
    req_b    = b_b;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("held_not_ready", 32'(req_ready), 32'd0);
      chk("held_b_kept", 32'(sc_b), 32'(b_a));
    end
    while (!resp_valid && vectors < 100000) begin
      @(posedge clk); #1;
    end
    chk("busy_count_a", 32'(resp_count), 32'(cnt_a));
    chk("busy_no_reaccept", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("reaccept_ready", 32'(req_ready), 32'd1);
    chk("reaccept_b_old", 32'(sc_b), 32'(b_a));
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("second_seed", 32'(sc_rand), 32'(fix(seed_b)));
    chk("second_b", 32'(sc_b), 32'(b_b));
    finish_job(seed_b, cnt_b, fin_b, 0);

    // Asynchronous reset in the middle of RUN, then an independent job.
    mode = 1;
    launch(8'h5A, 8'h80, 1'b0);
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    run_job(8'($urandom), 8'($urandom), 3, 0);

    for (int j = 0; j < 6; j++) begin
      run_job(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
